id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage of the pipeline (IF -> ID -> ID/EX register -> EX -> EX/WB -> WB).
- Decodes the fetched instruction, reads the register file and computes the EX-forwarding selects.
- Detects load-use hazards and drives the ID/EX register's input-side fields.
- Owns the architectural register file, which the WB stage writes through this block's write port.

Parameters:
DATA_W, 16, datapath/register width
RF_DEPTH, 8, number of registers (address width RA_W = clog2(RF_DEPTH) = 3)
INSTR_W, 16, instruction width (format below assumes defaults)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
instr  in  INSTR_W  instruction from IF
instr_valid  in  1  instr is meaningful this cycle
wb_wr_en  in  1  WB writes register file
wb_dst  in  RA_W  WB destination register
wb_data  in  DATA_W  WB write data
stall  out  1  hold IF/PC and keep instr stable next cycle
illegal_seen  out  1  sticky: an undefined opcode was decoded
wr_enx0  out  1  to ID/EX: instruction writes RF
ALUsrc1x0  out  2  to ID/EX: operand-1 select
ALUsrc2x0  out  2  to ID/EX: operand-2 select
ALUopx0  out  4  to ID/EX: opcode
immx0  out  DATA_W  to ID/EX: sign-extended immediate
dat1x0  out  DATA_W  to ID/EX: RF read data, src1
dat2x0  out  DATA_W  to ID/EX: RF read data, src2
dstx0  out  RA_W  to ID/EX: destination register

Behaviour:
Instruction format:
- [15:12] opcode, [11:9] dst, [8:6] src1, [5:3] src2, [5:0] imm6 (sign-extended to DATA_W).

Opcodes:
- 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (all reg,reg).
- 6 ADDI (src1, imm).
- 7 LD (address = src1+imm; data returns at WB).
- 8 SHL, 9 SHR (src1 shifted by imm[3:0]).
- A-F illegal.

ALUsrc encoding:
- 0 = RF data, 1 = immediate, 2 = forward EX result, 3 = reserved (never driven).
- ALUsrc2 = 1 for ADDI/LD/SHL/SHR, otherwise source-based.

Register file:
- RF_DEPTH x DATA_W flops.
- Written on clock edge when wb_wr_en && wb_dst != 0.
- r0 always reads 0; writes to r0 are discarded.
- Read is combinational with write-through bypass: if wb_wr_en && wb_dst == src && src != 0, the read returns wb_data in the same cycle.

EX tracker (registered, updated every non-reset edge with what this stage issued):
- ex_wr, ex_dst, ex_ld.

Forwarding:
- ALUsrcNx0 = 2 when ex_wr && ex_dst == srcN && srcN != 0 && !ex_ld.
- Otherwise the select is 0 (or 1 for immediate operands).
- Only sources the opcode actually uses are compared.

Load-use hazard:
- Condition: ex_ld && ex_wr && ex_dst != 0 && a used src == ex_dst, with instr_valid.
- Response: stall = 1 for exactly one cycle and a bubble is issued.
- Next cycle the LD is in WB, ex_ld = 0, and the RF bypass supplies the data (ALUsrc = 0). No second stall.
- IF must present the same instr while stall = 1.

Bubble (instr_valid = 0, stall, or illegal opcode):
- wr_enx0 = 0, ALUopx0 = 0, dstx0 = 0, ALUsrc* = 0, immx0 = 0, dat1x0 = 0, dat2x0 = 0.
- EX tracker loads ex_wr = 0.

wr_enx0:
- 1 for opcodes 1-9 with dst != 0.
- dst = 0 issues with wr_enx0 = 0 (no forward/hazard possible).

illegal_seen:
- Set on any valid opcode A-F; cleared only by reset.

Latency:
- ID outputs are combinational from instr, RF and tracker.
- The ID/EX register adds one cycle. Stall adds one cycle.

Reset (async, any time including mid-stall):
- All RF entries, tracker and illegal_seen clear to 0.
- While reset is high, every output is 0 (stall = 0, bubble fields).
- First edge after deassertion behaves as an empty pipeline.

Simultaneous events:
- WB write to the same register that EX forwards: EX forward wins (younger).
- Stall with instr_valid = 0: no stall.

Test Plan:
1. Reset mid-stall (LD r5 issued, ADD r6,r5,r1 stalled, assert reset) -> stall = 0, all x0 outputs 0; after release, ADD r1,r5,r5 reads dat1x0 = 0.
2. wb writes r2 = 5 and r3 = 7 in the same cycles as ADD r1,r2,r3 is decoded -> dat1x0 = 5, dat2x0 = 7, ALUsrc = 0/0, wr_enx0 = 1, dstx0 = 1.
3. ADD r1,r2,r3 then SUB r4,r1,r1 -> ALUsrc1x0 = 2, ALUsrc2x0 = 2, stall = 0; ADDI r4,r1,-1 -> ALUsrc1x0 = 2, ALUsrc2x0 = 1, immx0 = 0xFFFF.
4. LD r5,r2,0 then ADD r6,r5,r1 -> cycle 1 stall = 1 with bubble; cycle 2 stall = 0, ALUsrc1x0 = 0, dat1x0 = wb_data (0x1234 driven on WB).
5. ADDI r0,r1,3 then ADD r1,r0,r0 -> first wr_enx0 = 0; second ALUsrc = 0/0, dat1x0 = dat2x0 = 0; wb write to r0 is ignored.
6. Opcode 0xF with instr_valid = 1 -> bubble, illegal_seen = 1 and it stays 1 over 10 NOPs; a following ADD r1,r2,r3 does not forward from it.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, register file with write-through bypass,
// EX-forwarding selects, load-use stall and the input side of the ID/EX register.
module id_stage #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8,
  parameter int INSTR_W  = 16,
  localparam int RA_W    = $clog2(RF_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               wb_wr_en,
  input  logic [RA_W-1:0]    wb_dst,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               illegal_seen,
  output logic               wr_enx0,
  output logic [1:0]         ALUsrc1x0,
  output logic [1:0]         ALUsrc2x0,
  output logic [3:0]         ALUopx0,
  output logic [DATA_W-1:0]  immx0,
  output logic [DATA_W-1:0]  dat1x0,
  output logic [DATA_W-1:0]  dat2x0,
  output logic [RA_W-1:0]    dstx0
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd7;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_FWD = 2'd2;

  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic              ex_wr_q, ex_wr_d;
  logic [RA_W-1:0]   ex_dst_q, ex_dst_d;
  logic              ex_ld_q, ex_ld_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        op_s;
  logic [RA_W-1:0]   dst_s, src1_s, src2_s;
  logic [5:0]        imm6_s;
  logic              legal_s, uses1_s, uses2_s, imm_op_s;
  logic              hazard_s, issue_s, fwd1_s, fwd2_s;
  logic [DATA_W-1:0] rd1_s, rd2_s;

  assign op_s   = instr[15:12];
  assign dst_s  = instr[11:9];
  assign src1_s = instr[8:6];
  assign src2_s = instr[5:3];
  assign imm6_s = instr[5:0];

  // Opcode classification: which operands are used and whether it is defined.
  always_comb begin
    legal_s  = 1'b1;
    uses1_s  = 1'b0;
    uses2_s  = 1'b0;
    imm_op_s = 1'b0;
    case (op_s)
      4'd0: begin
        legal_s = 1'b1;
      end
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        uses1_s = 1'b1;
        uses2_s = 1'b1;
      end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        uses1_s  = 1'b1;
        imm_op_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Register-file reads; r0 is hard zero, a same-cycle WB write is bypassed.
  always_comb begin
    if (src1_s == '0) begin
      rd1_s = '0;
    end else if (wb_wr_en && (wb_dst == src1_s)) begin
      rd1_s = wb_data;
    end else begin
      rd1_s = rf_q[src1_s];
    end
    if (src2_s == '0) begin
      rd2_s = '0;
    end else if (wb_wr_en && (wb_dst == src2_s)) begin
      rd2_s = wb_data;
    end else begin
      rd2_s = rf_q[src2_s];
    end
  end

  // Hazard, forwarding and the ID/EX input fields; anything not issued is a bubble.
  always_comb begin
    hazard_s = instr_valid && !reset && ex_ld_q && ex_wr_q && (ex_dst_q != '0) &&
               ((uses1_s && (src1_s == ex_dst_q)) || (uses2_s && (src2_s == ex_dst_q)));
    issue_s  = instr_valid && !reset && legal_s && (op_s != OP_NOP) && !hazard_s;
    fwd1_s   = uses1_s && ex_wr_q && !ex_ld_q && (src1_s != '0) && (ex_dst_q == src1_s);
    fwd2_s   = uses2_s && ex_wr_q && !ex_ld_q && (src2_s != '0) && (ex_dst_q == src2_s);

    stall     = hazard_s;
    wr_enx0   = 1'b0;
    ALUsrc1x0 = SEL_RF;
    ALUsrc2x0 = SEL_RF;
    ALUopx0   = 4'd0;
    immx0     = '0;
    dat1x0    = '0;
    dat2x0    = '0;
    dstx0     = '0;
    if (issue_s) begin
      wr_enx0   = (dst_s != '0);
      ALUopx0   = op_s;
      dstx0     = dst_s;
      ALUsrc1x0 = fwd1_s ? SEL_FWD : SEL_RF;
      dat1x0    = uses1_s ? rd1_s : '0;
      if (imm_op_s) begin
        ALUsrc2x0 = SEL_IMM;
        immx0     = {{(DATA_W-6){imm6_s[5]}}, imm6_s};
      end else begin
        ALUsrc2x0 = fwd2_s ? SEL_FWD : SEL_RF;
        dat2x0    = uses2_s ? rd2_s : '0;
      end
    end else begin
      wr_enx0 = 1'b0;
    end

    ex_wr_d   = issue_s && (dst_s != '0);
    ex_dst_d  = issue_s ? dst_s : '0;
    ex_ld_d   = issue_s && (op_s == OP_LD);
    illegal_d = illegal_q || (instr_valid && !legal_s);
  end

  // Register file storage; r0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_wr_en && (wb_dst != '0)) begin
      rf_q[wb_dst] <= wb_data;
    end
  end

  // EX tracker and sticky illegal-opcode flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_wr_q   <= 1'b0;
      ex_dst_q  <= '0;
      ex_ld_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ex_wr_q   <= ex_wr_d;
      ex_dst_q  <= ex_dst_d;
      ex_ld_q   <= ex_ld_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_seen = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage with hand-written reset sequences.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        wb_wr_en;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic        stall, illegal_seen, wr_enx0;
  logic [1:0]  ALUsrc1x0, ALUsrc2x0;
  logic [3:0]  ALUopx0;
  logic [15:0] immx0, dat1x0, dat2x0;
  logic [2:0]  dstx0;

  int n_total = 0;
  int n_pass  = 0;

  id_stage dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .wb_wr_en(wb_wr_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .stall(stall), .illegal_seen(illegal_seen), .wr_enx0(wr_enx0),
    .ALUsrc1x0(ALUsrc1x0), .ALUsrc2x0(ALUsrc2x0), .ALUopx0(ALUopx0),
    .immx0(immx0), .dat1x0(dat1x0), .dat2x0(dat2x0), .dstx0(dstx0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] instr;
    logic        v;
    logic        we;
    logic [2:0]  wd;
    logic [15:0] wdat;
    logic        stall;
    logic        wr;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [3:0]  op;
    logic [15:0] imm;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  dst;
    logic        ill;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input logic [5:0] imm);
    return {op, d, a, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input logic v, input logic we,
                              input logic [2:0] wd, input logic [15:0] wdat,
                              input logic st, input logic wr, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [3:0] op,
                              input logic [15:0] imm, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [2:0] dst,
                              input logic ill);
    return '{ins, v, we, wd, wdat, st, wr, s1, s2, op, imm, d1, d2, dst, ill};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " stall"}, {15'd0, stall}, 16'd0);
    chk({tag, " wr_en"}, {15'd0, wr_enx0}, 16'd0);
    chk({tag, " op"}, {12'd0, ALUopx0}, 16'd0);
    chk({tag, " srcs"}, {12'd0, ALUsrc1x0, ALUsrc2x0}, 16'd0);
    chk({tag, " imm"}, immx0, 16'd0);
    chk({tag, " dat1"}, dat1x0, 16'd0);
    chk({tag, " dat2"}, dat2x0, 16'd0);
    chk({tag, " dst"}, {13'd0, dstx0}, 16'd0);
  endtask

  task automatic drive(input logic [15:0] ins, input logic v, input logic we,
                       input logic [2:0] wd, input logic [15:0] wdat);
    instr = ins; instr_valid = v; wb_wr_en = we; wb_dst = wd; wb_data = wdat;
  endtask

  initial begin
    logic [15:0] add123, add651, ld520;
    add123 = enc_r(4'd1, 3'd1, 3'd2, 3'd3);
    add651 = enc_r(4'd1, 3'd6, 3'd5, 3'd1);
    ld520  = enc_i(4'd7, 3'd5, 3'd2, 6'd0);

    vec[0]  = mk(16'h0000, 1'b0, 1'b1, 3'd3, 16'h0007,
                 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
    vec[1]  = mk(add123, 1'b1, 1'b1, 3'd2, 16'h0005,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h0005, 16'h0007, 3'd1, 1'b0);
    vec[2]  = mk(enc_r(4'd2, 3'd4, 3'd1, 3'd1), 1'b1, 1'b1, 3'd1, 16'h0011,
                 1'b0, 1'b1, 2'd2, 2'd2, 4'd2, 16'h0000, 16'h0011, 16'h0011, 3'd4, 1'b0);
    vec[3]  = mk(add123, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h0005, 16'h0007, 3'd1, 1'b0);
    vec[4]  = mk(enc_i(4'd6, 3'd4, 3'd1, 6'h3F), 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd2, 2'd1, 4'd6, 16'hFFFF, 16'h0011, 16'h0000, 3'd4, 1'b0);
    // EX forward must win over a same-cycle WB write of the same register
    vec[5]  = mk(enc_r(4'd1, 3'd5, 3'd4, 3'd4), 1'b1, 1'b1, 3'd4, 16'h00AA,
                 1'b0, 1'b1, 2'd2, 2'd2, 4'd1, 16'h0000, 16'h00AA, 16'h00AA, 3'd5, 1'b0);
    vec[6]  = mk(ld520, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd1, 4'd7, 16'h0000, 16'h0005, 16'h0000, 3'd5, 1'b0);
    vec[7]  = mk(add651, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
    vec[8]  = mk(add651, 1'b1, 1'b1, 3'd5, 16'h1234,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h1234, 16'h0011, 3'd6, 1'b0);
    vec[9]  = mk(enc_i(4'd6, 3'd0, 3'd1, 6'd3), 1'b1, 1'b1, 3'd0, 16'h5555,
                 1'b0, 1'b0, 2'd0, 2'd1, 4'd6, 16'h0003, 16'h0011, 16'h0000, 3'd0, 1'b0);
    vec[10] = mk(enc_r(4'd1, 3'd1, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h0000, 16'h0000, 3'd1, 1'b0);
    vec[11] = mk(16'hF4D8, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
    vec[12] = mk(add123, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h0005, 16'h0007, 3'd1, 1'b1);
    for (int i = 13; i < 23; i++) begin
      vec[i] = mk(16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000,
                  1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1);
    end
    vec[23] = mk(ld520, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd1, 4'd7, 16'h0000, 16'h0005, 16'h0000, 3'd5, 1'b1);
    vec[24] = mk(add651, 1'b0, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1);
    vec[25] = mk(add651, 1'b1, 1'b0, 3'd0, 16'h0000,
                 1'b0, 1'b1, 2'd0, 2'd0, 4'd1, 16'h0000, 16'h1234, 16'h0011, 3'd6, 1'b1);

    // Reset held with a valid instruction present: every output must be zero.
    reset = 1'b1;
    drive(add123, 1'b1, 1'b1, 3'd2, 16'h0009);
    @(posedge clock); #1;
    @(negedge clock);
    chk_bubble("reset");
    chk("reset illegal_seen", {15'd0, illegal_seen}, 16'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].instr, vec[i].v, vec[i].we, vec[i].wd, vec[i].wdat);
      @(negedge clock);
      chk($sformatf("v%0d stall", i), {15'd0, stall}, {15'd0, vec[i].stall});
      chk($sformatf("v%0d wr_en", i), {15'd0, wr_enx0}, {15'd0, vec[i].wr});
      chk($sformatf("v%0d src1", i), {14'd0, ALUsrc1x0}, {14'd0, vec[i].s1});
      chk($sformatf("v%0d src2", i), {14'd0, ALUsrc2x0}, {14'd0, vec[i].s2});
      chk($sformatf("v%0d op", i), {12'd0, ALUopx0}, {12'd0, vec[i].op});
      chk($sformatf("v%0d imm", i), immx0, vec[i].imm);
      chk($sformatf("v%0d dat1", i), dat1x0, vec[i].d1);
      chk($sformatf("v%0d dat2", i), dat2x0, vec[i].d2);
      chk($sformatf("v%0d dst", i), {13'd0, dstx0}, {13'd0, vec[i].dst});
      chk($sformatf("v%0d illegal_seen", i), {15'd0, illegal_seen}, {15'd0, vec[i].ill});
      @(posedge clock); #1;
    end

    // Reset asserted asynchronously in the middle of a load-use stall.
    drive(ld520, 1'b1, 1'b0, 3'd0, 16'h0000);
    @(negedge clock);
    chk("ms ld stall", {15'd0, stall}, 16'd0);
    @(posedge clock); #1;
    drive(add651, 1'b1, 1'b0, 3'd0, 16'h0000);
    @(negedge clock);
    chk("ms stall before reset", {15'd0, stall}, 16'd1);
    #1 reset = 1'b1;
    #1;
    chk_bubble("ms in reset");
    chk("ms illegal cleared", {15'd0, illegal_seen}, 16'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(enc_r(4'd1, 3'd1, 3'd5, 3'd5), 1'b1, 1'b0, 3'd0, 16'h0000);
    @(negedge clock);
    chk("post stall", {15'd0, stall}, 16'd0);
    chk("post src1", {14'd0, ALUsrc1x0}, 16'd0);
    chk("post dat1", dat1x0, 16'd0);
    chk("post dat2", dat2x0, 16'd0);
    chk("post wr_en", {15'd0, wr_enx0}, 16'd1);
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
